// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream and writes it into instruction memory
// as 32-bit words, holding the CPU until the whole program has been loaded.
//
// Parameters
//   BASE_ADDR  byte address of the first word written (bits [1:0] ignored)
//   BIG_ENDIAN 1: first byte of each word lands in [31:24]; 0: in [7:0]
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   start, length   begin a load of 'length' words (1..256); sampled in IDLE
//   byte_valid/data byte stream from the source
//   byte_ready      byte accepted this cycle (RECV only)
//   mem_we/addr/data instruction-memory write port (one cycle per word)
//   cpu_hold        CPU held while 1; drops when a load completes
//   busy            load in progress
//   done            one-cycle pulse on load completion
//   error           one-cycle pulse when start is rejected (length == 0)
module imem_loader #(
  parameter logic [9:0] BASE_ADDR  = 10'd0,
  parameter bit         BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  length,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [9:0] BASE_ALIGNED = {BASE_ADDR[9:2], 2'b00};

  state_t      state, state_nxt;
  logic [8:0]  len_q;
  logic [8:0]  word_cnt;
  logic [8:0]  word_cnt_inc;
  logic [1:0]  byte_cnt;
  logic [9:0]  addr_q;
  logic [31:0] word_q;
  logic        hold_q;
  logic        error_q;
  logic        start_ok;

  assign word_cnt_inc = word_cnt + 9'd1;
  assign start_ok     = start && (length != 9'd0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    cpu_hold   = hold_q;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_ok) state_nxt = RECV;
      end
      RECV: begin
        byte_ready = 1'b1;
        if (byte_valid && (byte_cnt == 2'd3)) state_nxt = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        // word_cnt still holds the pre-write count here
        if (word_cnt_inc == len_q) state_nxt = DONE;
        else                       state_nxt = RECV;
      end
      DONE: begin
        done      = 1'b1;
        cpu_hold  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q    <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      addr_q   <= BASE_ALIGNED;
      word_q   <= '0;
      hold_q   <= 1'b1;
      error_q  <= 1'b0;
    end else begin
      error_q <= (state == IDLE) && start && (length == 9'd0);
      case (state)
        IDLE: begin
          if (start_ok) begin
            len_q    <= length;
            addr_q   <= BASE_ALIGNED;
            byte_cnt <= '0;
            word_cnt <= '0;
            hold_q   <= 1'b1;
          end
        end
        RECV: begin
          if (byte_valid) begin
            if (BIG_ENDIAN) word_q <= {word_q[23:0], byte_data};
            else            word_q <= {byte_data, word_q[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        WRITE: begin
          addr_q   <= addr_q + 10'd4;
          word_cnt <= word_cnt_inc;
        end
        DONE: hold_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign mem_addr = addr_q;
  assign mem_data = word_q;
  assign error    = error_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 10'd0, meaning the byte address of the first word written (word-aligned; bits [1:0] ignored and treated as 0).
REQ-002 SHALL have parameter BIG_ENDIAN, default 1, meaning that the first received byte of each word lands in [31:24]; when 0, the first byte lands in [7:0].
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: the reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request to begin a load; sampled only in IDLE.
REQ-006 SHALL have port length, input, 9 bits: the number of 32-bit words to load (1..256); sampled with start.
REQ-007 SHALL have port byte_valid, input, 1 bit: the source presents byte_data.
REQ-008 SHALL have port byte_data, input, 8 bits: the program byte stream.
REQ-009 SHALL have port byte_ready, output, 1 bit: the loader accepts byte_data this cycle.
REQ-010 SHALL have port mem_we, output, 1 bit: the instruction-memory write enable.
REQ-011 SHALL have port mem_addr, output, 10 bits: the byte address of the write.
REQ-012 SHALL have port mem_data, output, 32 bits: the assembled instruction word.
REQ-013 SHALL have port cpu_hold, output, 1 bit: while 1, the CPU is held (no fetch or PC advance).
REQ-014 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-015 SHALL have port done, output, 1 bit: a one-cycle pulse on load completion.
REQ-016 SHALL have port error, output, 1 bit: a one-cycle pulse when start is rejected.

Function
REQ-017 SHALL implement the states IDLE, RECV, WRITE and DONE.
REQ-018 In IDLE, on start with length!=0, the block SHALL latch length, set the address to BASE_ADDR, clear the byte and word counters, set cpu_hold=1, and go to RECV.
REQ-019 In IDLE, on start with length==0, the block SHALL pulse error for 1 cycle and stay in IDLE with cpu_hold unchanged.
REQ-020 A byte SHALL transfer only when byte_valid and byte_ready are both 1; byte_ready SHALL be 1 only in RECV.
REQ-021 Each accepted byte SHALL shift into the word register per BIG_ENDIAN, and the 2-bit byte counter SHALL increment.
REQ-022 On acceptance of the 4th byte, the FSM SHALL go to WRITE, and the 2-bit byte counter SHALL wrap to 0.
REQ-023 In WRITE, the block SHALL assert mem_we=1 for exactly 1 cycle with mem_addr equal to the current address and mem_data equal to the assembled word.
REQ-024 In WRITE, the address SHALL increment by 4 modulo 1024 (wraps 10'h3FC->10'h000), and the word counter SHALL increment.
REQ-025 After WRITE, the FSM SHALL go to DONE if the word count equals the latched length; otherwise it SHALL go back to RECV.
REQ-026 Throughput SHALL be at most 1 word per 5 cycles: 4 byte cycles plus 1 write cycle, with no byte accepted during WRITE.
REQ-027 In DONE, the block SHALL pulse done=1 for 1 cycle, drive cpu_hold=0, and go to IDLE the next cycle.
REQ-028 busy SHALL be 1 in RECV, WRITE and DONE, and 0 in IDLE.
REQ-029 start SHALL be ignored while busy=1, and error SHALL NOT pulse in that case.
REQ-030 byte_valid without byte_ready SHALL be ignored, and gaps in byte_valid SHALL stall RECV indefinitely with no timeout.
REQ-031 mem_we SHALL be 0 outside WRITE; mem_addr and mem_data are don't-care when mem_we=0.
REQ-032 A new start after DONE SHALL reassert cpu_hold and restart from BASE_ADDR.

Reset
REQ-033 When reset=1 at a clock edge, the FSM SHALL enter IDLE, with byte_ready=0, mem_we=0, busy=0, done=0, error=0, cpu_hold=1, all counters 0 and the address set to BASE_ADDR.
REQ-034 Reset SHALL override every other input, including mid-load; partial words SHALL be discarded and no write issued.
REQ-035 cpu_hold SHALL remain 1 after reset until the first completed load.

Verification
REQ-036 length=1, bytes 8C,01,00,04 back-to-back, BIG_ENDIAN=1 -> one mem_we at addr 0 with data 32'h8C010004; done pulses 1 cycle after the write; cpu_hold falls.
REQ-037 BIG_ENDIAN=0, same bytes -> data 32'h0400018C.
REQ-038 length=3, byte_valid toggling every other cycle -> 3 writes at 0,4,8; no byte accepted during WRITE cycles; exactly 12 bytes consumed.
REQ-039 BASE_ADDR=10'h3F8, length=3 -> writes at 3F8, 3FC, 000.
REQ-040 start with length=0 -> error pulse, busy stays 0; start during RECV -> ignored, load completes normally.
REQ-041 reset asserted after 2 bytes of word 2 -> no further writes, IDLE, cpu_hold=1; a fresh load afterwards writes from BASE_ADDR with correct data.
